// File: rtl/rgb_seq_pkg.sv
// Shared types and default parameters for the RGB LED pattern sequencer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package rgb_seq_pkg;

    localparam int TICK_DIV_DEF = 48000;  // 1 ms tick at 48 MHz
    localparam int PWM_BITS_DEF = 8;
    localparam int STEPS_DEF    = 8;
    localparam int DUR_BITS_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SHOW = 2'd2,
        NEXT = 2'd3
    } seq_state_t;

    // One pattern table entry at the default widths.
    typedef struct packed {
        logic [PWM_BITS_DEF-1:0] r;
        logic [PWM_BITS_DEF-1:0] g;
        logic [PWM_BITS_DEF-1:0] b;
        logic [DUR_BITS_DEF-1:0] dur;
        logic                    last;
    } entry_t;

    // Step following idx: wrap to 0 after a 'last' entry or the end of the table.
    function automatic int next_step(input int idx, input logic last, input int steps);
        return (last || idx == steps - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rgb_pwm.sv
// Three-channel PWM: free-running counter with one registered comparator per colour.
// Latency: LED output reflects the compare of the previous cycle (1 cycle).
// Backpressure: none; enable low forces all LEDs dark at the next edge.
module rgb_pwm
    import rgb_seq_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [PWM_BITS-1:0] duty_r,
    input  logic [PWM_BITS-1:0] duty_g,
    input  logic [PWM_BITS-1:0] duty_b,
    output logic                led_r,
    output logic                led_g,
    output logic                led_b
);

    logic [PWM_BITS-1:0] pwm_cnt;

    // Period counter wraps naturally at 2^PWM_BITS; never restarted by the sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end

    // Strict less-than: duty 0 is always off and full-on is unreachable by design.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_r <= 1'b0;
            led_g <= 1'b0;
            led_b <= 1'b0;
        end else begin
            led_r <= enable && (pwm_cnt < duty_r);
            led_g <= enable && (pwm_cnt < duty_g);
            led_b <= enable && (pwm_cnt < duty_b);
        end
    end

endmodule

// File: rtl/rgb_sequencer.sv
// Plays a programmable colour/duration pattern on the RGB LED while run is high.
// Latency: run rise -> LOAD at edge 1, SHOW at edge 2, first LED high at edge 3.
// Backpressure: cfg_ready is high only in IDLE; writes are refused while playing.
module rgb_sequencer
    import rgb_seq_pkg::*;
#(
    parameter  int TICK_DIV = TICK_DIV_DEF,
    parameter  int PWM_BITS = PWM_BITS_DEF,
    parameter  int STEPS    = STEPS_DEF,
    parameter  int DUR_BITS = DUR_BITS_DEF,
    localparam int IDX_W    = $clog2(STEPS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [PWM_BITS-1:0] cfg_r,
    input  logic [PWM_BITS-1:0] cfg_g,
    input  logic [PWM_BITS-1:0] cfg_b,
    input  logic [DUR_BITS-1:0] cfg_dur,
    input  logic                cfg_last,
    input  logic                run,
    output logic                busy,
    output logic [IDX_W-1:0]    step_idx,
    output logic                led_r,
    output logic                led_g,
    output logic                led_b
);

    localparam int                TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    // Entry layout matches rgb_seq_pkg::entry_t, resized to this instance's widths.
    typedef struct packed {
        logic [PWM_BITS-1:0] r;
        logic [PWM_BITS-1:0] g;
        logic [PWM_BITS-1:0] b;
        logic [DUR_BITS-1:0] dur;
        logic                last;
    } step_t;

    seq_state_t          state;
    seq_state_t          state_nxt;
    step_t               tbl [STEPS];
    step_t               act;
    logic [TICK_W-1:0]   tick_cnt;
    logic [DUR_BITS-1:0] dur_cnt;
    logic                tick;
    logic                step_done;
    logic                cfg_wr;

    assign cfg_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign cfg_wr    = cfg_valid && cfg_ready;
    assign tick      = (state == SHOW) && (tick_cnt == TICK_LAST);
    // dur == 0 never finishes: the step holds until run drops.
    assign step_done = tick && (act.dur != '0) && (dur_cnt == DUR_BITS'(1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: run low overrides everything and parks the FSM in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run) state_nxt = LOAD;
            LOAD:    state_nxt = SHOW;
            SHOW:    if (step_done) state_nxt = NEXT;
            NEXT:    state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
        if (!run) state_nxt = IDLE;
    end

    // Pattern table: written only from IDLE, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STEPS; i++) tbl[i] <= '0;
        end else if (cfg_wr) begin
            tbl[cfg_idx] <= {cfg_r, cfg_g, cfg_b, cfg_dur, cfg_last};
        end
    end

    // Step pointer: restarts at 0 whenever playback is stopped or begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      step_idx <= '0;
        else if (!run || state == IDLE)  step_idx <= '0;
        else if (state == NEXT)          step_idx <= IDX_W'(next_step(int'(step_idx), act.last, STEPS));
    end

    // Active entry latch, tick prescaler and per-step duration countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act      <= '0;
            tick_cnt <= '0;
            dur_cnt  <= '0;
        end else begin
            case (state)
                LOAD: begin
                    act      <= tbl[step_idx];
                    tick_cnt <= '0;
                    dur_cnt  <= tbl[step_idx].dur;
                end
                SHOW: begin
                    tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
                    if (tick && (act.dur != '0) && (dur_cnt != '0))
                        dur_cnt <= dur_cnt - DUR_BITS'(1);
                end
                default: tick_cnt <= '0;
            endcase
        end
    end

    // Gating with run darkens the LEDs on the same edge that leaves SHOW for IDLE.
    rgb_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable ((state == SHOW) && run),
        .duty_r (act.r),
        .duty_g (act.g),
        .duty_b (act.b),
        .led_r  (led_r),
        .led_g  (led_g),
        .led_b  (led_b)
    );

endmodule

// File: tb/tb_rgb_sequencer.sv
// Self-checking bench for rgb_sequencer against a step-timeline reference model.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_rgb_sequencer;

    localparam int TICK_DIV = 4;
    localparam int PWM_BITS = 4;
    localparam int STEPS    = 4;
    localparam int DUR_BITS = 16;
    localparam int IDX_W    = 2;
    localparam int PERIOD   = 1 << PWM_BITS;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                cfg_valid = 1'b0;
    logic                cfg_ready;
    logic [IDX_W-1:0]    cfg_idx = '0;
    logic [PWM_BITS-1:0] cfg_r = '0;
    logic [PWM_BITS-1:0] cfg_g = '0;
    logic [PWM_BITS-1:0] cfg_b = '0;
    logic [DUR_BITS-1:0] cfg_dur = '0;
    logic                cfg_last = 1'b0;
    logic                run = 1'b0;
    logic                busy;
    logic [IDX_W-1:0]    step_idx;
    logic                led_r;
    logic                led_g;
    logic                led_b;

    int n_cmp = 0;
    int n_err = 0;

    rgb_sequencer #(
        .TICK_DIV (TICK_DIV),
        .PWM_BITS (PWM_BITS),
        .STEPS    (STEPS),
        .DUR_BITS (DUR_BITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_idx   (cfg_idx),
        .cfg_r     (cfg_r),
        .cfg_g     (cfg_g),
        .cfg_b     (cfg_b),
        .cfg_dur   (cfg_dur),
        .cfg_last  (cfg_last),
        .run       (run),
        .busy      (busy),
        .step_idx  (step_idx),
        .led_r     (led_r),
        .led_g     (led_g),
        .led_b     (led_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Playback is a timeline: each step spans dur*TICK_DIV+2 cycles counted from
    // its LOAD cycle (LOAD, dur*TICK_DIV SHOW cycles, NEXT); dur 0 never ends.
    int m_r [STEPS];
    int m_g [STEPS];
    int m_b [STEPS];
    int m_dur [STEPS];
    bit m_last [STEPS];
    bit m_play = 0;
    int m_idx = 0;
    int m_t = 0;
    int m_pwm = 0;
    bit m_lr = 0, m_lg = 0, m_lb = 0;

    // 0 idle, 1 load, 2 show, 3 next
    function automatic int phase_now();
        if (!m_play) return 0;
        if (m_t == 0) return 1;
        if (m_dur[m_idx] == 0) return 2;
        return (m_t == m_dur[m_idx] * TICK_DIV + 1) ? 3 : 2;
    endfunction

    initial begin
        for (int i = 0; i < STEPS; i++) begin
            m_r[i] = 0; m_g[i] = 0; m_b[i] = 0; m_dur[i] = 0; m_last[i] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < STEPS; i++) begin
                    m_r[i] = 0; m_g[i] = 0; m_b[i] = 0; m_dur[i] = 0; m_last[i] = 0;
                end
                m_play = 0; m_idx = 0; m_t = 0; m_pwm = 0;
                m_lr = 0; m_lg = 0; m_lb = 0;
            end else begin
                int ph;
                ph = phase_now();
                m_lr = (ph == 2) && run && (m_pwm < m_r[m_idx]);
                m_lg = (ph == 2) && run && (m_pwm < m_g[m_idx]);
                m_lb = (ph == 2) && run && (m_pwm < m_b[m_idx]);
                m_pwm = (m_pwm + 1) % PERIOD;
                if (!m_play) begin
                    if (cfg_valid) begin
                        m_r[cfg_idx] = int'(cfg_r); m_g[cfg_idx] = int'(cfg_g);
                        m_b[cfg_idx] = int'(cfg_b); m_dur[cfg_idx] = int'(cfg_dur);
                        m_last[cfg_idx] = cfg_last;
                    end
                    if (run) begin m_play = 1; m_idx = 0; m_t = 0; end
                end else if (!run) begin
                    m_play = 0; m_idx = 0; m_t = 0;
                end else if (ph == 3) begin
                    m_idx = (m_last[m_idx] || m_idx == STEPS - 1) ? 0 : m_idx + 1;
                    m_t = 0;
                end else begin
                    m_t++;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        check("busy", int'(busy), int'(m_play));
        check("cfg_ready", int'(cfg_ready), int'(!m_play));
        check("step_idx", int'(step_idx), m_idx);
        check("led_r", int'(led_r), int'(m_lr));
        check("led_g", int'(led_g), int'(m_lg));
        check("led_b", int'(led_b), int'(m_lb));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int idx, input int r, input int g, input int b,
                      input int dur, input bit last);
        cfg_idx = IDX_W'(idx); cfg_r = PWM_BITS'(r); cfg_g = PWM_BITS'(g);
        cfg_b = PWM_BITS'(b); cfg_dur = DUR_BITS'(dur); cfg_last = last;
        cfg_valid = 1'b1;
        cyc(1);
        cfg_valid = 1'b0;
    endtask

    // Watch step_idx for 40 cycles after run rises; dur=1 steps change every TICK_DIV+2.
    task automatic seq_watch(input string tag, input int wrap_at);
        int prev, last_c, n;
        prev = int'(step_idx); last_c = -1; n = 0;
        for (int c = 0; c < 40; c++) begin
            cyc(1);
            if (int'(step_idx) != prev) begin
                check({tag, "_next"}, int'(step_idx), (prev == wrap_at) ? 0 : prev + 1);
                if (last_c >= 0) check({tag, "_gap"}, c - last_c, TICK_DIV + 2);
                last_c = c; prev = int'(step_idx); n++;
            end
        end
        check({tag, "_steps"}, n, 6);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n, hr, hg, hb, nz, found;
        int h_r [2];
        int h_b [2];
        int h_p [2];
        h_r = '{8, 4}; h_b = '{15, 0}; h_p = '{16, 62};

        // Reset with run and cfg_valid high: nothing may start or be written.
        run = 1'b1; cfg_valid = 1'b1; cfg_r = 4'd15; cfg_dur = 16'd3;
        cyc(3);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(cfg_ready), 1);
        check("rst_leds", int'({led_r, led_g, led_b}), 0);
        run = 1'b0; cfg_valid = 1'b0; rst_n = 1'b1;
        cyc(6);
        check("idle_hold", int'(busy), 0);

        // Single entry, dur 2, last: step 0 replays every 10 cycles.
        wr(0, 8, 0, 15, 2, 1'b1);
        run = 1'b1;
        nz = 0;
        for (int c = 0; c < 40; c++) begin cyc(1); if (step_idx != '0) nz++; end
        check("one_step_idx", nz, 0);
        run = 1'b0; cyc(2);

        // Four dur-1 steps, then entry 1 marked last.
        for (int e = 0; e < STEPS; e++) wr(e, 12, 8, 4, 1, 1'b0);
        run = 1'b1;
        seq_watch("seq4", 3);
        run = 1'b0; cyc(2);
        wr(1, 12, 8, 4, 1, 1'b1);
        run = 1'b1;
        seq_watch("seq2", 1);

        // Stop mid-SHOW on step 1 with an LED lit.
        found = 0;
        for (int c = 0; c < 40; c++) begin
            cyc(1);
            if (m_idx == 1 && phase_now() == 2 && m_lr) begin found = 1; break; end
        end
        check("stop_wait", found, 1);
        run = 1'b0;
        cyc(1);
        check("stop_busy", int'(busy), 0);
        check("stop_leds", int'({led_r, led_g, led_b}), 0);
        check("stop_idx", int'(step_idx), 0);

        // Hold-forever steps: duty over whole PWM periods.
        for (int k = 0; k < 2; k++) begin
            run = 1'b0; cyc(2);
            wr(0, h_r[k], 0, h_b[k], 0, 1'b0);
            run = 1'b1;
            cyc(3);
            hr = 0; hg = 0; hb = 0; nz = 0;
            for (int c = 0; c < h_p[k] * PERIOD; c++) begin
                cyc(1);
                hr += int'(led_r); hg += int'(led_g); hb += int'(led_b);
                if (step_idx != '0 || !busy) nz++;
            end
            check("hold_r", hr, h_r[k] * h_p[k]);
            check("hold_g", hg, 0);
            check("hold_b", hb, h_b[k] * h_p[k]);
            check("hold_stay", nz, 0);
        end

        // Config writes during playback must be refused; replay exposes any leak.
        run = 1'b0; cyc(2);
        wr(0, 15, 15, 15, 1, 1'b0);
        run = 1'b1; cyc(3);
        cfg_valid = 1'b1; cfg_idx = '0; cfg_r = '0; cfg_g = '0; cfg_b = '0; cfg_dur = '0;
        cyc(20);
        check("play_ready", int'(cfg_ready), 0);
        cfg_valid = 1'b0; run = 1'b0; cyc(2);
        run = 1'b1; cyc(40);

        // Asynchronous reset mid-SHOW with an LED lit.
        run = 1'b0; cyc(2);
        wr(0, 15, 15, 15, 0, 1'b0);
        run = 1'b1;
        found = 0;
        for (int c = 0; c < 30; c++) begin
            cyc(1);
            if (phase_now() == 2 && m_lr) begin found = 1; break; end
        end
        check("arst_wait", found, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_leds", int'({led_r, led_g, led_b}), 0);
        check("arst_busy", int'(busy), 0);
        cyc(2);
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 40; c++) begin cyc(1); n += int'(led_r) + int'(led_g) + int'(led_b); end
        check("dark_leds", n, 0);
        check("dark_busy", int'(busy), 1);

        // Randomised tables, run drops and config noise.
        for (int it = 0; it < 30; it++) begin
            run = 1'b0; cyc(2);
            for (int e = 0; e < STEPS; e++)
                wr(e, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                   $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
            run = 1'b1;
            repeat ($urandom_range(10, 60)) begin
                cyc(1);
                run       = ($urandom_range(0, 19) != 0);
                cfg_valid = ($urandom_range(0, 1) == 1);
                cfg_idx   = IDX_W'($urandom_range(0, STEPS - 1));
                cfg_r     = PWM_BITS'($urandom_range(0, 15));
                cfg_g     = PWM_BITS'($urandom_range(0, 15));
                cfg_b     = PWM_BITS'($urandom_range(0, 15));
                cfg_dur   = DUR_BITS'($urandom_range(0, 3));
                cfg_last  = ($urandom_range(0, 3) == 0);
            end
            cfg_valid = 1'b0;
        end
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
